// File: rtl/regfile_hazard_scoreboard_if.sv
// Decode-issue and writeback signal bundle for the register-file hazard scoreboard.
// master = decode/writeback side, slave = scoreboard.
interface regfile_hazard_scoreboard_if #(
    parameter int ADDR_W = 5
);
    // Handshake: id_ready is a function of pending state and flush only and never
    // looks at id_valid; an instruction issues in exactly the cycles where
    // id_valid and id_ready are both high, which is what the issue output reports.
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic [ADDR_W-1:0] id_rd;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_writes_rd;
    logic              id_ready;
    logic              issue;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic              flush;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_writes_rd,
        output wb_valid, wb_rd, flush,
        input  id_ready, issue
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_writes_rd,
        input  wb_valid, wb_rd, flush,
        output id_ready, issue
    );
endinterface

// File: rtl/regfile_hazard_scoreboard.sv
// Register-file interlock: tracks outstanding writes and stalls decode on RAW/WAW hazards.
// Define WB_BYPASS_EN to let a same-cycle writeback release a dependent instruction.
module regfile_hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter int STALL_CNT_W = 16,
    parameter int STALL_LIMIT = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    regfile_hazard_scoreboard_if.slave sb,
    output logic [NUM_REGS-1:0]    pend_mask,
    output logic                   busy,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   deadlock,
    output logic                   err_spurious
);
    localparam int RUN_W = $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STALL_LIMIT);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STALL_LIMIT - 1);

    logic [NUM_REGS-1:0] eff_pend;
    logic [NUM_REGS-1:0] pend_next;
    logic [RUN_W-1:0]    run_cnt;
    logic                hazard;
    logic                stall;
    logic                spurious_wb;

`ifdef WB_BYPASS_EN
    logic [NUM_REGS-1:0] wb_hit;
    assign wb_hit   = sb.wb_valid ? (NUM_REGS'(1) << sb.wb_rd) : '0;
    assign eff_pend = pend_mask & ~wb_hit;
`else
    assign eff_pend = pend_mask;
`endif

    // x0 is hardwired, so an index of zero never forms a dependency.
    assign hazard = (sb.id_use_rs1   && eff_pend[sb.id_rs1] && (sb.id_rs1 != '0))
                  | (sb.id_use_rs2   && eff_pend[sb.id_rs2] && (sb.id_rs2 != '0))
                  | (sb.id_writes_rd && eff_pend[sb.id_rd]  && (sb.id_rd  != '0));

    assign sb.id_ready = ~hazard & ~sb.flush;
    assign sb.issue    = sb.id_valid & sb.id_ready;
    assign stall       = sb.id_valid & ~sb.id_ready;
    assign busy        = |pend_mask;

    assign spurious_wb = sb.wb_valid && (sb.wb_rd != '0) && !pend_mask[sb.wb_rd] && !sb.flush;

    // Clear is applied before set so a same-cycle issue to the written-back rd wins.
    always_comb begin
        pend_next = pend_mask;
        if (sb.flush) begin
            pend_next = '0;
        end else begin
            if (sb.wb_valid) pend_next[sb.wb_rd] = 1'b0;
            if (sb.issue && sb.id_writes_rd) pend_next[sb.id_rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_mask    <= '0;
            stall_cnt    <= '0;
            run_cnt      <= '0;
            deadlock     <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            pend_mask <= pend_next;

            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;

            // The run counter saturates at the limit; deadlock latches on the limit-th stall.
            if (stall && !sb.flush) begin
                if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
                if (run_cnt >= RUN_LAST) deadlock <= 1'b1;
            end else begin
                run_cnt <= '0;
            end

            if (spurious_wb) err_spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_hazard_scoreboard.sv
// Directed self-checking bench for regfile_hazard_scoreboard (default or WB_BYPASS_EN build).
module tb_regfile_hazard_scoreboard;
    localparam int NUM_REGS    = 32;
    localparam int ADDR_W      = 5;
    localparam int STALL_CNT_W = 16;
    localparam int STALL_LIMIT = 1024;
`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic                   clock;
    logic                   reset;
    logic [NUM_REGS-1:0]    pend_mask;
    logic                   busy;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   deadlock;
    logic                   err_spurious;

    int total;
    int bad;
    int exp_stall;

    regfile_hazard_scoreboard_if #(.ADDR_W(ADDR_W)) bus ();

    regfile_hazard_scoreboard #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .STALL_CNT_W(STALL_CNT_W), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clock(clock), .reset(reset), .sb(bus.slave),
        .pend_mask(pend_mask), .busy(busy), .stall_cnt(stall_cnt),
        .deadlock(deadlock), .err_spurious(err_spurious)
    );

    // clock/reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // driver tasks; inputs change only at the falling edge
    task automatic drive_id(input logic v, input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                            input logic [ADDR_W-1:0] rd, input logic u1, input logic u2, input logic w);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_use_rs1   = u1;
        bus.id_use_rs2   = u2;
        bus.id_writes_rd = w;
    endtask

    task automatic drive_wb(input logic v, input logic [ADDR_W-1:0] rd);
        bus.wb_valid = v;
        bus.wb_rd    = rd;
    endtask

    task automatic idle();
        drive_id(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive_wb(1'b0, '0);
        bus.flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        repeat (2) @(negedge clock);
        #1;
        total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL reset_pend: got %h want %h", pend_mask, 32'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (bus.id_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.id_ready); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        total++; if ({deadlock, err_spurious} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {deadlock, err_spurious}); end
        reset = 1'b1;
        step();
        exp_stall = 0;
    endtask

    task automatic test_raw();
        drive_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
        #1;
        total++; if (bus.issue !== 1'b1) begin bad++; $display("FAIL raw_first_issue: got %b want 1", bus.issue); end
        step();
        total++; if (pend_mask !== 32'h20) begin bad++; $display("FAIL raw_pend5: got %h want %h", pend_mask, 32'h20); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL raw_busy: got %b want 1", busy); end
        drive_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1);
        #1;
        total++; if ({bus.id_ready, bus.issue} !== 2'b00) begin bad++; $display("FAIL raw_stall: got %b want 00", {bus.id_ready, bus.issue}); end
        step();
        exp_stall = exp_stall + 1;
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL raw_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        drive_wb(1'b1, 5'd5);
        #1;
        total++; if (bus.issue !== BYP) begin bad++; $display("FAIL raw_wb_issue: got %b want %b", bus.issue, BYP); end
        step();
        if (!BYP) begin
            exp_stall = exp_stall + 1;
            total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL raw_wb_clear: got %h want %h", pend_mask, 32'h0); end
            total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL raw_stall_cnt2: got %0d want %0d", stall_cnt, exp_stall); end
            drive_wb(1'b0, '0);
            #1;
            total++; if (bus.issue !== 1'b1) begin bad++; $display("FAIL raw_late_issue: got %b want 1", bus.issue); end
            step();
        end
        total++; if (pend_mask !== 32'h40) begin bad++; $display("FAIL raw_pend6: got %h want %h", pend_mask, 32'h40); end
        idle();
        drive_wb(1'b1, 5'd6);
        step();
        idle();
        total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL raw_drain: got %h want %h", pend_mask, 32'h0); end
    endtask

    task automatic test_same_cycle();
        drive_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
        step();
        total++; if (pend_mask !== 32'h80) begin bad++; $display("FAIL same_pend7: got %h want %h", pend_mask, 32'h80); end
        drive_wb(1'b1, 5'd7);
        #1;
        total++; if (bus.issue !== BYP) begin bad++; $display("FAIL same_issue: got %b want %b", bus.issue, BYP); end
        step();
        if (!BYP) exp_stall = exp_stall + 1;
        total++; if (pend_mask !== (BYP ? 32'h80 : 32'h0)) begin bad++; $display("FAIL same_pend_after: got %h want %h", pend_mask, (BYP ? 32'h80 : 32'h0)); end
        idle();
        if (BYP) begin
            drive_wb(1'b1, 5'd7);
            step();
            idle();
        end
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL same_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_x0();
        drive_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        drive_wb(1'b1, 5'd0);
        #1;
        total++; if (bus.issue !== 1'b1) begin bad++; $display("FAIL x0_issue: got %b want 1", bus.issue); end
        step();
        total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL x0_pend: got %h want %h", pend_mask, 32'h0); end
        total++; if (err_spurious !== 1'b0) begin bad++; $display("FAIL x0_err: got %b want 0", err_spurious); end
        idle();
        drive_wb(1'b1, 5'd9);
        step();
        idle();
        total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL spurious_set: got %b want 1", err_spurious); end
        total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL spurious_pend: got %h want %h", pend_mask, 32'h0); end
        step();
        total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL spurious_sticky: got %b want 1", err_spurious); end
    endtask

    task automatic test_flush();
        drive_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1);
        step();
        drive_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1);
        step();
        total++; if (pend_mask !== 32'h18) begin bad++; $display("FAIL flush_pre: got %h want %h", pend_mask, 32'h18); end
        drive_id(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b1);
        bus.flush = 1'b1;
        #1;
        total++; if ({bus.id_ready, bus.issue} !== 2'b00) begin bad++; $display("FAIL flush_block: got %b want 00", {bus.id_ready, bus.issue}); end
        step();
        exp_stall = exp_stall + 1;
        idle();
        total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL flush_pend: got %h want %h", pend_mask, 32'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL flush_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL flush_keeps_err: got %b want 1", err_spurious); end
    endtask

    task automatic test_deadlock();
        drive_id(1'b1, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1);
        step();
        drive_id(1'b1, 5'd0, 5'd2, 5'd11, 1'b0, 1'b1, 1'b1);
        repeat (STALL_LIMIT - 1) step();
        total++; if (deadlock !== 1'b0) begin bad++; $display("FAIL deadlock_early: got %b want 0", deadlock); end
        step();
        exp_stall = exp_stall + STALL_LIMIT;
        total++; if (deadlock !== 1'b1) begin bad++; $display("FAIL deadlock_set: got %b want 1", deadlock); end
        drive_wb(1'b1, 5'd2);
        #1;
        total++; if (bus.issue !== BYP) begin bad++; $display("FAIL deadlock_wb_issue: got %b want %b", bus.issue, BYP); end
        step();
        if (!BYP) begin
            exp_stall = exp_stall + 1;
            drive_wb(1'b0, '0);
            step();
        end
        idle();
        drive_wb(1'b1, 5'd11);
        step();
        idle();
        total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL deadlock_drain: got %h want %h", pend_mask, 32'h0); end
        total++; if (deadlock !== 1'b1) begin bad++; $display("FAIL deadlock_sticky: got %b want 1", deadlock); end
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL deadlock_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_mid_reset();
        drive_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1);
        step();
        total++; if (pend_mask !== 32'h100) begin bad++; $display("FAIL midrst_pre: got %h want %h", pend_mask, 32'h100); end
        drive_id(1'b1, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL midrst_pend: got %h want %h", pend_mask, 32'h0); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL midrst_stall: got %0d want 0", stall_cnt); end
        total++; if ({deadlock, err_spurious} !== 2'b00) begin bad++; $display("FAIL midrst_flags: got %b want 00", {deadlock, err_spurious}); end
        total++; if (bus.id_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", bus.id_ready); end
        idle();
        step();
        reset = 1'b1;
        step();
        total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL midrst_after: got %h want %h", pend_mask, 32'h0); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_stall = 0;
        test_reset();
        test_raw();
        test_same_cycle();
        test_x0();
        test_flush();
        test_deadlock();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
